fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Control sequencer directly upstream of the LC-3 datapath: drives its LD_*, Gate*, PCMUX controls
//  and the active-low SRAM strobes to run the fetch loop MAR<-PC, PC<-PC+1; MDR<-M[MAR]; IR<-MDR,
//  then parks in PAUSE. Run/Continue are debounced, active-high push-buttons, edge-detected here.
//  Top-level wiring: controls -> datapath; Mem_* -> SRAM; MDR_In is driven by SRAM data.
// PARAMETERS
//  MEM_WAIT    3   SRAM read wait cycles (1..15) spent in READ state, LD_MDR asserted on the last one
// PORTS
//  Clk         in   1   system clock, all state on rising edge
//  Reset       in   1   synchronous, active-high; overrides all other inputs
//  Run         in   1   start fetching (rising edge detected)
//  Continue    in   1   leave PAUSE for next fetch (rising edge detected)
//  LD_MAR      out  1   datapath MAR load
//  LD_PC       out  1   datapath PC load
//  LD_MDR      out  1   datapath MDR load (from MDR_In)
//  LD_IR       out  1   datapath IR load (from bus)
//  GatePC      out  1   bus <- PC
//  GateMDR     out  1   bus <- MDR
//  GateALU     out  1   always 0 in this block
//  GateMARMUX  out  1   always 0 in this block
//  PCMUX       out  2   00=PC+1, 01=bus, 10=adder; this block drives only 00
//  Mem_CE      out  1   SRAM chip enable, active-low
//  Mem_OE      out  1   SRAM output enable, active-low
//  Mem_WE      out  1   SRAM write enable, active-low; held 1 (fetch never writes)
//  State_Out   out  3   encoded current state, for hex display/debug
// BEHAVIOUR
//  - States (State_Out): HALTED=0, FETCH_MAR=1, READ=2, LOAD_IR=3, PAUSE=4.
//  - Reset (sync): state=HALTED, wait counter=0, edge regs=0. All LD_*/Gate*=0, PCMUX=00,
//    Mem_CE=Mem_OE=Mem_WE=1, State_Out=0 in the cycle after Reset is sampled; reset mid-read
//    aborts the read with no LD_MDR/LD_IR pulse.
//  - Edge detect: run_rise = Run & ~run_q; cont_rise = Continue & ~cont_q; run_q/cont_q
//    register the raw inputs every cycle. A button held high never re-triggers.
//  - Outputs are Moore (decoded from state only); every control not listed for a state is
//    0, strobes not listed are 1.
//  - HALTED: no outputs. run_rise -> FETCH_MAR, else stay.
//  - FETCH_MAR (1 cycle): GatePC=1, LD_MAR=1, LD_PC=1, PCMUX=00. -> READ, counter<=0.
//  - READ (MEM_WAIT cycles): Mem_CE=0, Mem_OE=0 every cycle; counter +1 per cycle; LD_MDR=1
//    only when counter==MEM_WAIT-1, then -> LOAD_IR. Counter is 4 bits, never wraps.
//  - LOAD_IR (1 cycle): GateMDR=1, LD_IR=1. -> PAUSE.
//  - PAUSE: no outputs. cont_rise -> FETCH_MAR; Continue held from before entry does not leave.
//  - Fetch latency Run edge -> LD_IR pulse: MEM_WAIT+2 cycles; exactly one LD_MAR, LD_PC,
//    LD_MDR, LD_IR pulse per fetch.
//  - Run/Continue edges in states other than HALTED/PAUSE are ignored (not queued).
//  - Gate one-hot: at most one of GatePC/GateMDR/GateALU/GateMARMUX high in any cycle.
//  - Unreachable encodings 5..7 -> HALTED next cycle, outputs as HALTED.
// STRUCTURE
//  - Shared package lc3_pkg: typedef enum logic [2:0] fetch_state_t (values above);
//    PCMUX_PC1=2'b00, PCMUX_BUS=2'b01, PCMUX_ADDER=2'b10 constants, reused by datapath.
//  - One sub-module: btn_edge (1-bit register + rising-edge pulse), instantiated for Run and
//    Continue. Main module: state register, wait counter, output decode.
// TESTING
//  - Reset held 2 cycles mid-READ -> next cycle State_Out=0, Mem_CE=Mem_OE=1, no LD_MDR/LD_IR ever.
//  - MEM_WAIT=3, Run 0->1 in HALTED -> LD_MAR/LD_PC/GatePC high cycle 1, Mem_CE/OE low cycles
//    2-4, LD_MDR cycle 4 only, LD_IR+GateMDR cycle 5, State_Out=4 cycle 6.
//  - Run held high through the whole fetch into PAUSE -> stays PAUSE; Continue 0->1 -> FETCH_MAR
//    next cycle; Continue held 10 cycles -> exactly one fetch.
//  - Continue pulsed during READ -> ignored; after reaching PAUSE controller stays there.
//  - MEM_WAIT=1 -> READ lasts 1 cycle with LD_MDR=1; full fetch 3 cycles; MEM_WAIT=15 -> 15.
//  - Assertion every cycle: Gate* one-hot-or-zero, Mem_WE==1, PCMUX==00, GateALU==GateMARMUX==0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Types and constants shared by the LC-3 fetch sequencer and the datapath it controls.
package lc3_pkg;

  typedef enum logic [2:0] {
    ST_HALTED    = 3'd0,
    ST_FETCH_MAR = 3'd1,
    ST_READ      = 3'd2,
    ST_LOAD_IR   = 3'd3,
    ST_PAUSE     = 3'd4
  } fetch_state_t;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

endpackage

// File: rtl/fetch_ctrl_btn_edge.sv
// Rising-edge detector for an already debounced push-button: one-cycle pulse per press.
module btn_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_btn_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_btn_q <= 1'b0;
    else         r_btn_q <= i_btn;
  end

  // A button held high keeps r_btn_q high, so it cannot fire again until released.
  assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/fetch_ctrl.sv
// LC-3 fetch sequencer: MAR<-PC/PC<-PC+1, SRAM read into MDR, IR<-MDR, then park in PAUSE.
module fetch_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  output logic       LD_MAR,
  output logic       LD_PC,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [2:0] State_Out
);

  localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

  logic [2:0] r_state;
  logic [3:0] r_wait;
  logic       w_run_rise;
  logic       w_cont_rise;
  logic       w_last_wait;

  btn_edge u_run_edge (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_btn   (Run),
    .o_rise  (w_run_rise)
  );

  btn_edge u_cont_edge (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_btn   (Continue),
    .o_rise  (w_cont_rise)
  );

  assign w_last_wait = (r_wait == LAST_WAIT);

  // Button edges are only looked at in HALTED/PAUSE; anywhere else they are dropped, not queued.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_HALTED;
      r_wait  <= 4'd0;
    end else begin
      case (r_state)
        ST_HALTED: begin
          if (w_run_rise) r_state <= ST_FETCH_MAR;
        end
        ST_FETCH_MAR: begin
          r_state <= ST_READ;
          r_wait  <= 4'd0;
        end
        ST_READ: begin
          if (w_last_wait) r_state <= ST_LOAD_IR;
          else             r_wait  <= r_wait + 4'd1;
        end
        ST_LOAD_IR: r_state <= ST_PAUSE;
        ST_PAUSE: begin
          if (w_cont_rise) r_state <= ST_FETCH_MAR;
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  // Moore decode; SRAM strobes are active-low and the fetch path never writes.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_PC      = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    Mem_CE     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (r_state)
      ST_FETCH_MAR: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      ST_READ: begin
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        LD_MDR = w_last_wait;
      end
      ST_LOAD_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      default: ;
    endcase
  end

  assign State_Out = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl at MEM_WAIT = 3, 1 and 15, with per-cycle control invariants.
module tb_fetch_ctrl;

  // Output bundle: [0]LD_MAR [1]LD_PC [2]LD_MDR [3]LD_IR [4]GatePC [5]GateMDR [6]GateALU
  // [7]GateMARMUX [9:8]PCMUX [10]Mem_CE [11]Mem_OE [12]Mem_WE [15:13]State_Out
  localparam logic [15:0] E_HALTED = 16'h1C00;
  localparam logic [15:0] E_FETCH  = 16'h3C13;
  localparam logic [15:0] E_READ   = 16'h5000;
  localparam logic [15:0] E_RD_MDR = 16'h5004;
  localparam logic [15:0] E_LDIR   = 16'h7C28;
  localparam logic [15:0] E_PAUSE  = 16'h9C00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run3, cont3, run1, cont1, run15, cont15;
  wire [15:0] o3, o1, o15;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic chk_en   = 1'b0;
  logic [15:0] e1, e15;

  fetch_ctrl #(.MEM_WAIT(3)) dut3 (
    .Clk(clk), .Reset(reset), .Run(run3), .Continue(cont3),
    .LD_MAR(o3[0]), .LD_PC(o3[1]), .LD_MDR(o3[2]), .LD_IR(o3[3]),
    .GatePC(o3[4]), .GateMDR(o3[5]), .GateALU(o3[6]), .GateMARMUX(o3[7]),
    .PCMUX(o3[9:8]), .Mem_CE(o3[10]), .Mem_OE(o3[11]), .Mem_WE(o3[12]),
    .State_Out(o3[15:13])
  );

  fetch_ctrl #(.MEM_WAIT(1)) dut1 (
    .Clk(clk), .Reset(reset), .Run(run1), .Continue(cont1),
    .LD_MAR(o1[0]), .LD_PC(o1[1]), .LD_MDR(o1[2]), .LD_IR(o1[3]),
    .GatePC(o1[4]), .GateMDR(o1[5]), .GateALU(o1[6]), .GateMARMUX(o1[7]),
    .PCMUX(o1[9:8]), .Mem_CE(o1[10]), .Mem_OE(o1[11]), .Mem_WE(o1[12]),
    .State_Out(o1[15:13])
  );

  fetch_ctrl #(.MEM_WAIT(15)) dut15 (
    .Clk(clk), .Reset(reset), .Run(run15), .Continue(cont15),
    .LD_MAR(o15[0]), .LD_PC(o15[1]), .LD_MDR(o15[2]), .LD_IR(o15[3]),
    .GatePC(o15[4]), .GateMDR(o15[5]), .GateALU(o15[6]), .GateMARMUX(o15[7]),
    .PCMUX(o15[9:8]), .Mem_CE(o15[10]), .Mem_OE(o15[11]), .Mem_WE(o15[12]),
    .State_Out(o15[15:13])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic inv(input string tag, input logic [15:0] b);
    n_checks++;
    assert ($onehot0(b[7:4]) && b[7:6] === 2'b00 && b[12] === 1'b1 && b[9:8] === 2'b00) n_pass++;
    else $error("FAIL inv_%s: got %h expected onehot0 gates, ALU/MARMUX=0, WE=1, PCMUX=00", tag, b);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      inv("m3", o3);
      inv("m1", o1);
      inv("m15", o15);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {run3, cont3, run1, cont1, run15, cont15} = 6'b0;

    // Reset and idle in HALTED
    step();
    step();
    chk("rst_m3", o3, E_HALTED);
    chk("rst_m1", o1, E_HALTED);
    chk("rst_m15", o15, E_HALTED);
    reset  = 1'b0;
    chk_en = 1'b1;
    step();
    chk("idle_a", o3, E_HALTED);
    step();
    chk("idle_b", o3, E_HALTED);

    // Run edge, full fetch at MEM_WAIT=3; Run stays high throughout
    run3 = 1'b1;
    step(); chk("f_c1_fetch", o3, E_FETCH);
    step(); chk("f_c2_read", o3, E_READ);
    step(); chk("f_c3_read", o3, E_READ);
    step(); chk("f_c4_mdr", o3, E_RD_MDR);
    step(); chk("f_c5_ldir", o3, E_LDIR);
    step(); chk("f_c6_pause", o3, E_PAUSE);
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("run_held_pause%0d", i), o3, E_PAUSE);
    end

    // Continue held 10 cycles: exactly one fetch
    cont3 = 1'b1;
    step(); chk("c_c1_fetch", o3, E_FETCH);
    step(); chk("c_c2_read", o3, E_READ);
    step(); chk("c_c3_read", o3, E_READ);
    step(); chk("c_c4_mdr", o3, E_RD_MDR);
    step(); chk("c_c5_ldir", o3, E_LDIR);
    for (int c = 6; c <= 10; c++) begin
      step(); chk($sformatf("c_c%0d_pause", c), o3, E_PAUSE);
    end
    cont3 = 1'b0;
    run3  = 1'b0;
    step(); chk("c_release_pause", o3, E_PAUSE);

    // Continue pulsed during READ is dropped
    cont3 = 1'b1;
    step(); chk("p_c1_fetch", o3, E_FETCH);
    cont3 = 1'b0;
    step(); chk("p_c2_read", o3, E_READ);
    cont3 = 1'b1;
    step(); chk("p_c3_read", o3, E_READ);
    cont3 = 1'b0;
    step(); chk("p_c4_mdr", o3, E_RD_MDR);
    step(); chk("p_c5_ldir", o3, E_LDIR);
    step(); chk("p_c6_pause", o3, E_PAUSE);
    step(); chk("p_c7_pause", o3, E_PAUSE);
    step(); chk("p_c8_pause", o3, E_PAUSE);

    // MEM_WAIT=1 and MEM_WAIT=15 fetches side by side
    run1  = 1'b1;
    run15 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      e1  = (c == 1) ? E_FETCH : (c == 2) ? E_RD_MDR : (c == 3) ? E_LDIR : E_PAUSE;
      e15 = (c == 1) ? E_FETCH : (c <= 15) ? E_READ : (c == 16) ? E_RD_MDR :
            (c == 17) ? E_LDIR : E_PAUSE;
      chk($sformatf("w1_c%0d", c), o1, e1);
      chk($sformatf("w15_c%0d", c), o15, e15);
    end
    run1  = 1'b0;
    run15 = 1'b0;

    // Reset held 2 cycles in the middle of a read
    cont3 = 1'b1;
    step(); chk("r_c1_fetch", o3, E_FETCH);
    cont3 = 1'b0;
    step(); chk("r_c2_read", o3, E_READ);
    reset = 1'b1;
    step(); chk("r_abort_a", o3, E_HALTED);
    step(); chk("r_abort_b", o3, E_HALTED);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("r_after%0d_m3", i), o3, E_HALTED);
    end
    chk("r_after_m1", o1, E_HALTED);
    chk("r_after_m15", o15, E_HALTED);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
